// File: rtl/mips_dmem.sv
// mips_dmem: data memory for a single-cycle MIPS core.
// 256 x 32-bit RAM at byte addresses 0x000-0x3FF with a combinational
// read port and a write port clocked on the rising edge. Misaligned or
// unmapped accesses return zero, suppress the write and set a sticky err
// flag. err is cleared by err_clr; a new error in the same cycle wins.
// Optional feature macro: DMEM_MMIO_EN adds three memory-mapped registers:
//   0xFFFF0000 cyc_cnt (read-only), 0xFFFF0004 st_cnt (read-only),
//   0xFFFF0008 scratch (read/write).
// Without the macro, all 0xFFFF000x addresses are unmapped.
module mips_dmem (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] ALUresult,
    input  logic [31:0] writedata,
    input  logic        err_clr,
    output logic [31:0] readdata,
    output logic        err
);

    // RAM contents are deliberately not reset; words are undefined until written.
    logic [31:0] mem [0:255];

    logic [7:0]  word_idx;
    logic        misaligned;
    logic        ram_hit;
    logic        mmio_hit;
    logic [31:0] mmio_rdata;
    logic        acc_err;
    logic        ram_we;
    logic        err_q;
    logic        err_d;

    assign word_idx   = ALUresult[9:2];
    assign misaligned = |ALUresult[1:0];
    assign ram_hit    = (ALUresult[31:10] == 22'd0);

    // A write is blocked while reset is high, so a store that overlaps a
    // reset pulse never reaches the array.
    assign ram_we  = memwrite & ram_hit & ~misaligned & ~reset;
    assign acc_err = misaligned | (~ram_hit & ~mmio_hit);

`ifdef DMEM_MMIO_EN
    localparam logic [31:0] ADDR_CYC = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_ST  = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_SCR = 32'hFFFF_0008;

    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] st_cnt_q,  st_cnt_d;
    logic [31:0] scratch_q, scratch_d;
    logic        hit_cyc, hit_st, hit_scr;

    // Full-address compares: the register addresses are aligned, so a
    // misaligned address never hits and falls through to the error path.
    assign hit_cyc  = (ALUresult == ADDR_CYC);
    assign hit_st   = (ALUresult == ADDR_ST);
    assign hit_scr  = (ALUresult == ADDR_SCR);
    assign mmio_hit = hit_cyc | hit_st | hit_scr;

    // MMIO read mux; registers read 0 during reset because they are held cleared.
    always_comb begin
        mmio_rdata = 32'h0;
        if (hit_cyc) begin
            mmio_rdata = cyc_cnt_q;
        end else if (hit_st) begin
            mmio_rdata = st_cnt_q;
        end else if (hit_scr) begin
            mmio_rdata = scratch_q;
        end
    end

    // Next-state for counters and scratch; writes to the counters are ignored.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        st_cnt_d  = st_cnt_q + {31'd0, ram_we};
        scratch_d = scratch_q;
        if (memwrite && hit_scr) begin
            scratch_d = writedata;
        end
    end

    // MMIO register state, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt_q <= 32'h0;
            st_cnt_q  <= 32'h0;
            scratch_q <= 32'h0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            st_cnt_q  <= st_cnt_d;
            scratch_q <= scratch_d;
        end
    end
`else
    assign mmio_hit   = 1'b0;
    assign mmio_rdata = 32'h0;
`endif

    // Zero-latency load path: RAM word, MMIO register or 0 on any error.
    always_comb begin
        readdata = 32'h0;
        if (!misaligned) begin
            if (ram_hit) begin
                readdata = mem[word_idx];
            end else if (mmio_hit) begin
                readdata = mmio_rdata;
            end
        end
    end

    // RAM write port; reads see the old word until this edge.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[word_idx] <= writedata;
        end
    end

    // Sticky error next-state: clear first, then a new error overrides it.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (acc_err) begin
            err_d = 1'b1;
        end
    end

    // Sticky error flag, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_mips_dmem.sv
// tb_mips_dmem: directed scoreboard bench for mips_dmem.
// Stimulus pushes expected values into a queue and raises sample_ev; a
// separate monitor pops each entry and compares it with the DUT outputs.
// MMIO checks are compiled in when DMEM_MMIO_EN is defined.
module tb_mips_dmem;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] ALUresult;
    logic [31:0] writedata;
    logic        err_clr;
    logic [31:0] readdata;
    logic        err;

    typedef struct {
        string       name;
        bit          is_err;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    event sample_ev;
    int   total;
    int   bad;

    mips_dmem dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .ALUresult (ALUresult),
        .writedata (writedata),
        .err_clr   (err_clr),
        .readdata  (readdata),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must never hang.
    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: pop every queued expectation when the stimulus samples.
    initial begin
        chk_t        e;
        logic [31:0] got;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                got = e.is_err ? {31'd0, err} : readdata;
                total++;
                if (got !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got=%h want=%h", e.name, got, e.exp);
                end else begin
                    $display("ok   %s: got=%h", e.name, got);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] exp);
        chk_t e;
        e.name = name; e.is_err = 1'b0; e.exp = exp;
        q.push_back(e);
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic chk_err(input string name, input logic exp);
        chk_t e;
        e.name = name; e.is_err = 1'b1; e.exp = {31'd0, exp};
        q.push_back(e);
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; ALUresult = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1; memwrite = 1'b0; err_clr = 1'b0;
        ALUresult = 32'h400; writedata = 32'h0;

        // Reset state: unmapped read returns 0 and err held low.
        chk_rd("reset_rd_unmapped", 32'h0);
        chk_err("reset_err", 1'b0);
        tick();
        tick();
        reset = 1'b0; ALUresult = 32'h0;

        // Basic store then load.
        store(32'h10, 32'hDEADBEEF);
        chk_rd("store_load_0x10", 32'hDEADBEEF);
        chk_err("store_load_err", 1'b0);

        // Read during write: old word before the edge, new word after.
        memwrite = 1'b1; writedata = 32'h0000000A;
        chk_rd("rdw_before_edge", 32'hDEADBEEF);
        tick();
        memwrite = 1'b0;
        chk_rd("rdw_after_edge", 32'h0000000A);

        // Misaligned store: suppressed, reads 0, sets err.
        memwrite = 1'b1; ALUresult = 32'h12; writedata = 32'h5;
        chk_rd("misalign_rd", 32'h0);
        chk_err("misalign_err_before", 1'b0);
        tick();
        memwrite = 1'b0;
        chk_err("misalign_err_set", 1'b1);
        ALUresult = 32'h10;
        chk_rd("misalign_word_kept", 32'h0000000A);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk_err("err_clr", 1'b0);

        // Top and bottom words; store to 0x400 must not alias word 0.
        store(32'h3FC, 32'h12345678);
        store(32'h000, 32'h11111111);
        ALUresult = 32'h3FC;
        chk_rd("top_word_0x3fc", 32'h12345678);
        store(32'h400, 32'hBADBAD00);
        chk_err("unmapped_store_err", 1'b1);
        ALUresult = 32'h0;
        chk_rd("no_alias_word0", 32'h11111111);
        ALUresult = 32'h400;
        chk_rd("unmapped_rd", 32'h0);
        ALUresult = 32'h0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk_err("err_clr_2", 1'b0);

        // New error and clear in the same cycle: set wins.
        ALUresult = 32'h400; err_clr = 1'b1;
        tick();
        ALUresult = 32'h0;
        chk_err("set_beats_clr", 1'b1);
        tick();
        err_clr = 1'b0;
        chk_err("clr_after_set", 1'b0);

        // memwrite=0 leaves RAM unchanged.
        ALUresult = 32'h10; writedata = 32'hFFFFFFFF;
        tick();
        chk_rd("no_write_when_idle", 32'h0000000A);

`ifdef DMEM_MMIO_EN
        // Counters: reset pulse, 20 edges with 3 stores.
        ALUresult = 32'h0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            memwrite = (i == 3 || i == 7 || i == 11);
            ALUresult = 32'h20 + 32'(i);
            ALUresult[1:0] = 2'b00;
            writedata = 32'(i);
            tick();
        end
        memwrite = 1'b0;
        ALUresult = 32'hFFFF0000;
        chk_rd("cyc_cnt_20", 32'd20);
        ALUresult = 32'hFFFF0004;
        chk_rd("st_cnt_3", 32'd3);
        store(32'hFFFF0008, 32'h7);
        chk_rd("scratch_rw", 32'h7);
        chk_err("scratch_no_err", 1'b0);
        store(32'hFFFF0000, 32'h0);
        chk_err("ro_write_no_err", 1'b0);
        chk_rd("cyc_cnt_ignores_write", 32'd22);
`else
        // Without MMIO the register window is unmapped.
        ALUresult = 32'hFFFF0000;
        chk_rd("mmio_absent_rd", 32'h0);
        tick();
        ALUresult = 32'h0;
        chk_err("mmio_absent_err", 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
`endif

        // Async reset between edges while err=1.
        ALUresult = 32'h401;
        tick();
        ALUresult = 32'h10;
        chk_err("pre_reset_err", 1'b1);
        reset = 1'b1;
        chk_err("async_reset_err", 1'b0);
        chk_rd("reset_reads_ram", 32'h0000000A);
`ifdef DMEM_MMIO_EN
        ALUresult = 32'hFFFF0000;
        chk_rd("async_reset_cyc", 32'h0);
        ALUresult = 32'hFFFF0008;
        chk_rd("async_reset_scratch", 32'h0);
`endif
        // Store attempted during reset is suppressed.
        memwrite = 1'b1; ALUresult = 32'h10; writedata = 32'h00000BAD;
        tick();
        memwrite = 1'b0;
        reset = 1'b0;
        chk_rd("write_blocked_in_reset", 32'h0000000A);
        store(32'h10, 32'h55);
        chk_rd("write_after_reset", 32'h55);

        #2;
        if (q.size() != 0) begin
            bad += q.size();
            total += q.size();
            $display("FAIL scoreboard_drain: got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_dmem.md
MIPS_DMEM -- requirements
Module: mips_dmem

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port memwrite, input, 1 bit: store request from the processor for the current cycle.
REQ-004 SHALL have port ALUresult, input, 32 bits: byte address of the access.
REQ-005 SHALL have port writedata, input, 32 bits: store data.
REQ-006 SHALL have port err_clr, input, 1 bit: synchronous clear of the sticky error flag.
REQ-007 SHALL have port readdata, output, 32 bits: load data returned to the processor.
REQ-008 SHALL have port err, output, 1 bit: sticky access-error flag.

Function
REQ-009 SHALL implement 256 x 32-bit RAM at byte addresses 0x000-0x3FF, word index = ALUresult[9:2].
REQ-010 SHALL drive readdata combinationally from ALUresult; load latency is zero cycles, as the single-cycle processor requires.
REQ-011 SHALL write writedata into RAM on the rising clk edge when memwrite=1 and the address is a valid aligned RAM address.
REQ-012 SHALL return the old word on readdata during a same-address write cycle, and the new word from the edge onward.
REQ-013 SHALL treat an address with ALUresult[1:0]!=0 as misaligned: write suppressed, readdata=0.
REQ-014 SHALL treat an aligned address outside RAM and outside the MMIO window as unmapped: write suppressed, readdata=0.
REQ-015 SHALL set err on the edge ending any cycle with a misaligned or unmapped access, whether read or write.
REQ-016 SHALL clear err on the edge when err_clr=1; if a new error and err_clr occur in the same cycle, err SHALL stay 1 (set wins).
REQ-017 SHALL leave RAM contents unchanged when memwrite=0.

Reset
REQ-018 SHALL, while reset=1, force err=0, with effect immediately and not waiting for clk.
REQ-019 SHALL, while reset=1, force cyc_cnt=0, st_cnt=0 and scratch=0 (when MMIO is compiled in), with effect immediately and not waiting for clk.
REQ-020 SHALL not reset RAM contents; these are undefined until written.
REQ-021 SHALL suppress any write in progress when reset asserts mid-cycle; the first write takes effect on the first rising edge after reset=0.
REQ-022 SHALL drive readdata during reset from the RAM/MMIO decode of ALUresult, with MMIO registers reading 0.

Configuration
REQ-023 SHALL, with macro DMEM_MMIO_EN defined, map the following registers:
- 0xFFFF0000: cyc_cnt, read-only. Increments every clk edge after reset and wraps 0xFFFFFFFF->0.
- 0xFFFF0004: st_cnt, read-only. Increments on each committed RAM store and wraps.
- 0xFFFF0008: scratch, read/write.
REQ-024 SHALL ignore writes to cyc_cnt and st_cnt without setting err; misaligned MMIO accesses follow REQ-013.
REQ-025 SHALL, without DMEM_MMIO_EN, have no MMIO registers; all 0xFFFF000x addresses are unmapped per REQ-014.

Verification
REQ-026 SHALL cover basic store/load:
- Stimulus: reset pulse, then memwrite=1, ALUresult=0x10, writedata=0xDEADBEEF for one edge, then memwrite=0.
- Response: readdata=0xDEADBEEF at ALUresult=0x10; err=0.
REQ-027 SHALL cover read-during-write:
- Stimulus: 0x10 holds 0xDEADBEEF; write 0x0000000A to 0x10.
- Response: readdata=0xDEADBEEF before the edge and 0x0000000A after it.
REQ-028 SHALL cover a misaligned store:
- Stimulus: memwrite=1, ALUresult=0x12, writedata=0x5.
- Response: RAM word 0x10 unchanged; readdata=0 at 0x12; err=1 after the edge.
- Then: err_clr=1 for one edge gives err=0.
REQ-029 SHALL cover error set and clear in the same cycle:
- Stimulus: read unmapped 0x400 with err_clr=1 in the same cycle.
- Response: err=1.
REQ-030 SHALL cover the MMIO counters (DMEM_MMIO_EN defined):
- Stimulus: release reset, run 20 edges, with 3 RAM stores among them.
- Response: 0xFFFF0000 reads 20; 0xFFFF0004 reads 3.
- Then: writing 0x7 to 0xFFFF0008 reads back 0x7.
REQ-031 SHALL cover async reset mid-run:
- Stimulus: assert reset between edges while err=1.
- Response: err=0 and counters=0 immediately, without a clk edge.
